// File: rtl/dfx_packet_encap.sv
// dfx_packet_encap: frames DFX source words into header + payload packets for router input port 0.
// Define DFX_ENCAP_CHECKSUM_EN to append an XOR checksum trailer word to every packet.
module dfx_packet_encap #(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int PAYLOAD_WORDS     = 4,
  parameter int LEN_WIDTH         = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         src_valid,
  input  logic [AURORA_DATA_WIDTH-1:0] src_data,
  output logic                         src_ready,
  output logic                         ready_encap_dfx,
  input  logic [8:0]                   header_pkt_send,
  input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [AURORA_DATA_WIDTH-1:0] fifo_wr_data,
  output logic                         pkt_done,
  output logic                         busy
);
  localparam int CW = $clog2(PAYLOAD_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(PAYLOAD_WORDS - 1);
`ifdef DFX_ENCAP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HDR, PAYLOAD, TRAIL} state_t;
  logic [AURORA_DATA_WIDTH-1:0] r_xor;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HDR, PAYLOAD} state_t;
`endif
  state_t                       r_state, w_next;
  logic [8:0]                   r_hdr;
  logic [ADDR_WIDTH-1:0]        r_dst;
  logic [CW-1:0]                r_wcnt;
  logic                         r_pkt_done;
  logic                         w_xfer, w_last, w_done;
  logic [AURORA_DATA_WIDTH-1:0] w_hdr_word;
  assign w_hdr_word = {{(AURORA_DATA_WIDTH-9-ADDR_WIDTH-LEN_WIDTH){1'b0}},
                       LEN_WIDTH'(PAYLOAD_WORDS), r_dst, r_hdr};
  assign w_xfer = (r_state == PAYLOAD) && src_valid && !fifo_full;
  assign w_last = w_xfer && (r_wcnt == LAST);
  assign pkt_done = r_pkt_done;
  assign busy = (r_state != IDLE);
  always_comb begin
    w_next = r_state;
    src_ready = 1'b0;
    ready_encap_dfx = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_wr_data = '0;
    w_done = 1'b0;
    case (r_state)
      IDLE: w_next = src_valid ? REQ : IDLE;
      REQ: begin
        ready_encap_dfx = 1'b1;
        w_next = WAIT;
      end
      WAIT: w_next = HDR;
      HDR: begin
        fifo_wr_en = !fifo_full;
        fifo_wr_data = fifo_full ? '0 : w_hdr_word;
        w_next = fifo_full ? HDR : PAYLOAD;
      end
      PAYLOAD: begin
        src_ready = !fifo_full;
        fifo_wr_en = w_xfer;
        fifo_wr_data = w_xfer ? src_data : '0;
`ifdef DFX_ENCAP_CHECKSUM_EN
        w_next = w_last ? TRAIL : PAYLOAD;
`else
        w_next = w_last ? IDLE : PAYLOAD;
        w_done = w_last;
`endif
      end
`ifdef DFX_ENCAP_CHECKSUM_EN
      TRAIL: begin
        fifo_wr_en = !fifo_full;
        fifo_wr_data = fifo_full ? '0 : r_xor;
        w_next = fifo_full ? TRAIL : IDLE;
        w_done = !fifo_full;
      end
`endif
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hdr <= '0;
      r_dst <= '0;
      r_wcnt <= '0;
      r_pkt_done <= 1'b0;
`ifdef DFX_ENCAP_CHECKSUM_EN
      r_xor <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_pkt_done <= w_done;
      // controller header registers are stable by the end of WAIT
      if (r_state == WAIT) begin
        r_hdr <= header_pkt_send;
        r_dst <= router_dst_addr_send;
        r_wcnt <= '0;
`ifdef DFX_ENCAP_CHECKSUM_EN
        r_xor <= '0;
`endif
      end
      if (w_xfer) begin
        r_wcnt <= r_wcnt + CW'(1);
`ifdef DFX_ENCAP_CHECKSUM_EN
        r_xor <= r_xor ^ src_data;
`endif
      end
    end
  end
endmodule

// File: tb/tb_dfx_packet_encap.sv
// tb_dfx_packet_encap: directed checks of framing, latency, backpressure, source gaps, reset and back-to-back packets.
module tb_dfx_packet_encap;
  logic        clk = 1'b0, rst_n = 1'b0, src_valid = 1'b0, fifo_full = 1'b0;
  logic        src_ready, ready_encap_dfx, fifo_wr_en, pkt_done, busy;
  logic [63:0] src_data = '0, fifo_wr_data;
  logic [8:0]  header_pkt_send = '0;
  logic [9:0]  router_dst_addr_send = '0;
  int          vectors = 0, miscompares = 0;
  logic [63:0] wq[$], eq[$];

  always #5 clk = ~clk;

  dfx_packet_encap dut (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .ready_encap_dfx(ready_encap_dfx),
    .header_pkt_send(header_pkt_send), .router_dst_addr_send(router_dst_addr_send),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .pkt_done(pkt_done), .busy(busy)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(logic v, logic [63:0] d, logic f);
    src_valid = v;
    src_data = d;
    fifo_full = f;
    #1;
  endtask

  task automatic send(logic [63:0] d);
    set(1'b1, d, 1'b0);
    for (int i = 0; i < 50 && !src_ready; i++) tick();
    chk("send_timeout", 64'(src_ready), 64'd1);
    tick();
  endtask

  task automatic exp_pkt(logic [8:0] h, logic [9:0] a, logic [63:0] w0, w1, w2, w3);
    eq.push_back({37'd0, 8'd4, a, h});
    eq.push_back(w0);
    eq.push_back(w1);
    eq.push_back(w2);
    eq.push_back(w3);
`ifdef DFX_ENCAP_CHECKSUM_EN
    eq.push_back(w0 ^ w1 ^ w2 ^ w3);
`endif
  endtask

  task automatic cmpq(string tag);
    chk({tag, "_count"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size(); i++)
      chk(tag, (i < wq.size()) ? wq[i] : 64'hx, eq[i]);
    wq.delete();
    eq.delete();
  endtask

  always @(posedge clk) begin
    if (rst_n && fifo_wr_en) wq.push_back(fifo_wr_data);
    chk("wr_while_full", 64'(fifo_wr_en & fifo_full), 64'd0);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {58'd0, src_ready, ready_encap_dfx, fifo_wr_en, pkt_done, busy}, 64'd0);
    chk("rst_data", fifo_wr_data, 64'd0);
    rst_n = 1'b1;
    header_pkt_send = 9'h10A;
    router_dst_addr_send = 10'h155;
    tick();
    // basic framing, cycle by cycle
    set(1'b1, 64'd1, 1'b0);
    chk("idle_req", 64'(ready_encap_dfx), 64'd0);
    tick();
    chk("req_pulse", {62'd0, ready_encap_dfx, busy}, 64'd3);
    chk("req_nowr", {62'd0, fifo_wr_en, src_ready}, 64'd0);
    tick();
    chk("wait_req", {62'd0, ready_encap_dfx, fifo_wr_en}, 64'd0);
    tick();
    chk("hdr_en", {62'd0, fifo_wr_en, src_ready}, 64'd2);
    chk("hdr_word", fifo_wr_data, 64'h22AB0A);
    tick();
    chk("p0", {fifo_wr_data[61:0], fifo_wr_en, src_ready}, {62'd1, 2'b11});
    tick();
    set(1'b1, 64'd2, 1'b0);
    chk("p1", fifo_wr_data, 64'd2);
    tick();
    set(1'b1, 64'd4, 1'b0);
    chk("p2", fifo_wr_data, 64'd4);
    tick();
    set(1'b1, 64'd8, 1'b0);
    chk("p3", {fifo_wr_data[61:0], fifo_wr_en, pkt_done}, {62'd8, 2'b10});
    tick();
    set(1'b0, 64'd0, 1'b0);
`ifdef DFX_ENCAP_CHECKSUM_EN
    chk("trail", {fifo_wr_data[61:0], fifo_wr_en, pkt_done}, {62'hF, 2'b10});
    tick();
`endif
    chk("done_pulse", {62'd0, pkt_done, busy}, 64'd2);
    tick();
    chk("done_clear", 64'(pkt_done), 64'd0);
    exp_pkt(9'h10A, 10'h155, 64'd1, 64'd2, 64'd4, 64'd8);
    cmpq("basic");
    // backpressure in HDR and on payload word 2
    set(1'b1, 64'd1, 1'b0);
    tick();
    tick();
    set(1'b1, 64'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hdr", {61'd0, fifo_wr_en, src_ready, busy}, 64'd1);
    end
    set(1'b1, 64'd1, 1'b0);
    chk("bp_hdr_rel", 64'(fifo_wr_en), 64'd1);
    send(64'd1);
    set(1'b1, 64'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_pay", {62'd0, fifo_wr_en, src_ready}, 64'd0);
      tick();
    end
    send(64'd2);
    send(64'd4);
    send(64'd8);
    set(1'b0, 64'd0, 1'b0);
    tick();
    tick();
    exp_pkt(9'h10A, 10'h155, 64'd1, 64'd2, 64'd4, 64'd8);
    cmpq("backpressure");
    // source gap after payload word 1
    send(64'd1);
    set(1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gap_hold", {62'd0, busy, fifo_wr_en}, 64'd2);
    end
    send(64'd2);
    send(64'd4);
    send(64'd8);
    set(1'b0, 64'd0, 1'b0);
    tick();
    tick();
    exp_pkt(9'h10A, 10'h155, 64'd1, 64'd2, 64'd4, 64'd8);
    cmpq("gap");
    // reset mid-packet, then a fresh packet
    send(64'd1);
    send(64'd2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ctrl", {58'd0, src_ready, ready_encap_dfx, fifo_wr_en, pkt_done, busy}, 64'd0);
    chk("rstmid_data", fifo_wr_data, 64'd0);
    eq.push_back(64'h22AB0A);
    eq.push_back(64'd1);
    eq.push_back(64'd2);
    tick();
    cmpq("partial");
    header_pkt_send = 9'h055;
    router_dst_addr_send = 10'h0AA;
    rst_n = 1'b1;
    #1;
    chk("rstmid_idle", 64'(busy), 64'd0);
    tick();
    chk("rstmid_req", 64'(ready_encap_dfx), 64'd1);
    send(64'd3);
    send(64'd5);
    send(64'd7);
    send(64'd9);
    set(1'b0, 64'd0, 1'b0);
    tick();
    tick();
    exp_pkt(9'h055, 10'h0AA, 64'd3, 64'd5, 64'd7, 64'd9);
    cmpq("restart");
    // back-to-back with src_valid held high
    header_pkt_send = 9'h10A;
    router_dst_addr_send = 10'h155;
    send(64'd1);
    header_pkt_send = 9'h10E;
    send(64'd2);
    send(64'd4);
    send(64'd8);
`ifdef DFX_ENCAP_CHECKSUM_EN
    tick();
`endif
    chk("b2b_idle", {61'd0, busy, pkt_done, ready_encap_dfx}, 64'd2);
    tick();
    chk("b2b_req", 64'(ready_encap_dfx), 64'd1);
    send(64'd16);
    send(64'd32);
    send(64'd64);
    send(64'd128);
    set(1'b0, 64'd0, 1'b0);
    tick();
    tick();
    exp_pkt(9'h10A, 10'h155, 64'd1, 64'd2, 64'd4, 64'd8);
    exp_pkt(9'h10E, 10'h155, 64'd16, 64'd32, 64'd64, 64'd128);
    cmpq("b2b");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
